uart_tx: RTL and testbench

- Asynchronous serial transmitter, 8N1, LSB first, idle-high line. Pairs with uart_rx on the same link.
- Accepts one byte per start/ready handshake from the core or peripheral bus.
- Serialises the byte on tx using an internal baud divider; holds no FIFO.
- Sits next to uart_rx in the peripherals directory and shares baudgen.vh divisor macros.

---
 rtl/uart_tx.sv | 110 +++++++++++
 tb/tb_uart_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle-high line, start/ready handshake, no FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between d7 and the stop bit.

`ifndef B115200
`define B115200 104
`endif

module uart_tx #(
    parameter int unsigned BAUDRATE = `B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    localparam int BAUD_W = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(BAUDRATE - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TX   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [BAUD_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    tx_q, tx_d;
    logic                    ready_q, ready_d;
    logic [FRAME_BITS-1:0]   frame;

`ifdef UART_TX_PARITY_EN
    assign frame = {1'b1, ^data, data, 1'b0};
`else
    assign frame = {1'b1, data, 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;

        case (state_q)
            // DONE accepts a request exactly like IDLE, giving a one-cycle gap.
            IDLE, DONE: begin
                if (start) begin
                    state_d = TX;
                    shift_d = frame;
                end else begin
                    state_d = IDLE;
                end
            end
            TX: begin
                if (baud_cnt_q == BAUD_MAX) begin
                    shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_d == LAST_BIT) begin
                        state_d   = DONE;
                        bit_cnt_d = '0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                    bit_cnt_d  = bit_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '1;
            end
        endcase

        // Outputs are registered from the next-state view so tx changes on the accept edge.
        tx_d    = (state_d == TX) ? shift_d[0] : 1'b1;
        ready_d = (state_d != TX);
    end

    assign tx    = tx_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised self-checking bench for uart_tx: a time-based frame model predicts
// tx/ready every cycle and a mid-bit-sampling receiver decodes the line.

module tb_uart_tx;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] data;
    logic       tx;
    logic       ready;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    uart_tx #(.BAUDRATE(B)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] d, input int n);
        start = s;
        data  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReady(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) checkOutput("wait_ready_timeout", 32'd0, 32'd1);
    endtask

    // Reference model: a frame is a list of FB bits; bit k occupies cycles
    // [k*B, (k+1)*B) counted from the accept edge.
    bit          m_busy = 1'b0;
    int          m_t = 0;
    logic [10:0] m_bits = '1;
    logic [7:0]  exp_q[$];

    always @(posedge clk) begin
        if (rstn === 1'b0) begin
            if (m_busy && exp_q.size() > 0) void'(exp_q.pop_back());
            m_busy = 1'b0;
            m_t    = 0;
        end else if (start === 1'b1 && !m_busy) begin
            m_busy    = 1'b1;
            m_t       = 0;
            m_bits    = '1;
            m_bits[0] = 1'b0;
            m_bits[8:1] = data;
            if (FB == 11) m_bits[9] = ^data;
            exp_q.push_back(data);
        end else if (m_busy) begin
            m_t++;
            if (m_t == FB * B) m_busy = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            checkOutput("tx", 32'(tx), m_busy ? 32'(m_bits[m_t / B]) : 32'd1);
            checkOutput("ready", 32'(ready), m_busy ? 32'd0 : 32'd1);
        end
    end

    // Mid-bit sampling receiver, independent of the model's cycle bookkeeping.
    bit          rx_busy = 1'b0;
    int          rx_cnt = 0;
    logic [10:0] rx_bits;
    logic [7:0]  rx_byte;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            if (rstn === 1'b0) begin
                rx_busy = 1'b0;
            end else if (!rx_busy) begin
                if (tx === 1'b0) begin
                    rx_busy = 1'b1;
                    rx_cnt  = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % B == B / 2) begin
                    rx_bits[rx_cnt / B] = tx;
                    if (rx_cnt / B == FB - 1) begin
                        rx_busy = 1'b0;
                        rx_byte = rx_bits[8:1];
                        checkOutput("rx_start", 32'(rx_bits[0]), 32'd0);
                        checkOutput("rx_stop", 32'(rx_bits[FB-1]), 32'd1);
                        if (FB == 11) checkOutput("rx_parity", 32'(rx_bits[9]), 32'(^rx_byte));
                        if (exp_q.size() == 0) checkOutput("rx_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
                        else checkOutput("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rstn  = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1'b0, 8'h00, 50);

        applyStimulus(1'b1, 8'h55, 1);
        applyStimulus(1'b0, 8'h00, FB * B + 8);

        applyStimulus(1'b1, 8'hA5, 1);
        applyStimulus(1'b0, 8'h00, 9);
        applyStimulus(1'b1, 8'hFF, 1);
        applyStimulus(1'b0, 8'h00, FB * B + 8);

        applyStimulus(1'b1, 8'h00, 1);
        waitReady(FB * B + 10);
        data = 8'hC3;
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, FB * B + 8);

        applyStimulus(1'b1, 8'hF0, 1);
        applyStimulus(1'b0, 8'h00, 14);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(1'b0, 8'h00, 5);
        applyStimulus(1'b1, 8'h12, 1);
        applyStimulus(1'b0, 8'h00, FB * B + 8);

        applyStimulus(1'b1, 8'h07, 1);
        applyStimulus(1'b0, 8'h00, FB * B + 8);
        applyStimulus(1'b1, 8'h03, 1);
        applyStimulus(1'b0, 8'h00, FB * B + 8);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'($urandom), 1);
            for (int j = 0; j < int'($urandom_range(0, 60)); j++)
                applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom), 1);
        end
        applyStimulus(1'b0, 8'h00, FB * B + 12);

        checkOutput("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
